x25519_freeze_ser: RTL and testbench



---
 rtl/x25519_freeze_ser_if.sv | 38 +++
 rtl/x25519_freeze_ser.sv | 104 ++++++++++
 tb/tb_x25519_freeze_ser.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/x25519_freeze_ser_if.sv
// ============================================================================
// Module : x25519_freeze_ser_if
// Field-element-in / canonical-byte-stream-out bundle for the freeze stage.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface x25519_freeze_ser_if;
    logic         en;
    logic [263:0] a;
    logic         busy;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   out_byte;
    logic         out_last;

    modport master (
        output en,
        output a,
        output out_ready,
        input  busy,
        input  out_valid,
        input  out_byte,
        input  out_last
    );

    modport slave (
        input  en,
        input  a,
        input  out_ready,
        output busy,
        output out_valid,
        output out_byte,
        output out_last
    );
endinterface

`default_nettype wire

// File: rtl/x25519_freeze_ser.sv
// ============================================================================
// Module : x25519_freeze_ser
// Fully reduces a 264-bit element mod 2^255-19, streams 32 bytes LSB first.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module x25519_freeze_ser (
    input  wire logic            clk,
    input  wire logic            rst_n,
    x25519_freeze_ser_if.slave   bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FOLD = 2'd1;
    localparam logic [1:0] S_SUB  = 2'd2;
    localparam logic [1:0] S_SEND = 2'd3;

    localparam logic [255:0] C_P = {1'b0, {247{1'b1}}, 8'hED};

    logic [1:0]   state_q, state_d;
    logic [263:0] v_q, v_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [4:0]   idx_q, idx_d;

    logic [13:0]  w_mul;
    logic [263:0] w_fold;
    logic         w_ge;
    logic [255:0] w_diff;
    logic [8:0]   w_bitpos;

    // 2^255 == 19 (mod p): bits above 254 fold back in as 19x their value.
    assign w_mul    = 14'(v_q[263:255]) * 14'd19;
    assign w_fold   = {9'd0, v_q[254:0]} + {250'd0, w_mul};
    assign w_ge     = (v_q[255:0] >= C_P);
    assign w_diff   = v_q[255:0] - C_P;
    assign w_bitpos = {1'b0, idx_q, 3'b000};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            v_q     <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        v_d     = v_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (bus.en) begin
                    v_d     = bus.a;
                    cnt_d   = 2'd0;
                    state_d = S_FOLD;
                end
            end
            S_FOLD: begin
                v_d   = w_fold;
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd2) begin
                    state_d = S_SUB;
                end
            end
            S_SUB: begin
                if (w_ge) begin
                    v_d = {8'd0, w_diff};
                end
                idx_d   = 5'd0;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (bus.out_ready) begin
                    idx_d = idx_q + 5'd1;
                    if (idx_q == 5'd31) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy      = (state_q != S_IDLE);
        bus.out_valid = (state_q == S_SEND);
        bus.out_last  = (state_q == S_SEND) && (idx_q == 5'd31);
        bus.out_byte  = 8'd0;
        if (state_q == S_SEND) begin
            bus.out_byte = v_q[w_bitpos +: 8];
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_x25519_freeze_ser.sv
// ============================================================================
// Module : tb_x25519_freeze_ser
// Scoreboard bench: expected bytes come from (a mod p) computed directly.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_x25519_freeze_ser;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rand_ready = 1'b0;

    always #5 clk = ~clk;

    x25519_freeze_ser_if bus ();

    x25519_freeze_ser dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [263:0] p264;
    logic [7:0]   exp_q[$];
    logic         exp_last_q[$];
    int           checks = 0;
    int           passes = 0;

    task automatic chk(input string nm, input logic [263:0] act, input logic [263:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic push_expected(input logic [263:0] val);
        logic [263:0] r;
        r = val % p264;
        for (int i = 0; i < 32; i++) begin
            exp_q.push_back(r[8*i +: 8]);
            exp_last_q.push_back(i == 31);
        end
    endtask

    // Waits for the first idle cycle, issues en, then checks 4-cycle latency.
    task automatic start(input logic [263:0] val);
        int n;
        n = 0;
        while (bus.busy && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk("start_idle_wait", 264'(bus.busy), 264'(0));
        bus.en = 1'b1;
        bus.a  = val;
        @(posedge clk); #1;
        bus.en = 1'b0;
        push_expected(val);
        chk("busy_after_en", 264'(bus.busy), 264'(1));
        repeat (3) @(posedge clk);
        #1;
        chk("valid_before_E4", 264'(bus.out_valid), 264'(0));
        @(posedge clk); #1;
        chk("valid_after_E4", 264'(bus.out_valid), 264'(1));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((bus.busy || exp_q.size() != 0) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drained_queue", 264'(exp_q.size()), 264'(0));
        chk("drained_busy", 264'(bus.busy), 264'(0));
    endtask

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pops one expected byte per accepted beat; checks holding on stalls.
    initial begin
        logic       hold_pending;
        logic [7:0] hold_byte;
        logic       hold_last;
        logic [7:0] eb;
        logic       el;
        hold_pending = 1'b0;
        hold_byte    = 8'd0;
        hold_last    = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid) begin
                if (hold_pending) begin
                    chk("hold_byte", 264'(bus.out_byte), 264'(hold_byte));
                    chk("hold_last", 264'(bus.out_last), 264'(hold_last));
                end
                if (bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", 264'(1), 264'(0));
                    end else begin
                        eb = exp_q.pop_front();
                        el = exp_last_q.pop_front();
                        chk("out_byte", 264'(bus.out_byte), 264'(eb));
                        chk("out_last", 264'(bus.out_last), 264'(el));
                    end
                    hold_pending = 1'b0;
                end else begin
                    hold_pending = 1'b1;
                    hold_byte    = bus.out_byte;
                    hold_last    = bus.out_last;
                end
            end else begin
                hold_pending = 1'b0;
            end
        end
    end

    initial begin
        logic [263:0] vecs[6];
        logic [263:0] rv;
        p264   = (264'd1 << 255) - 264'd19;
        bus.en = 1'b0;
        bus.a  = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",      264'(bus.busy),      264'(0));
        chk("rst_out_valid", 264'(bus.out_valid), 264'(0));
        chk("rst_out_last",  264'(bus.out_last),  264'(0));
        chk("rst_out_byte",  264'(bus.out_byte),  264'(0));
        rst_n = 1'b1;

        vecs[0] = 264'd0;
        vecs[1] = p264;
        vecs[2] = p264 + 264'd1;
        vecs[3] = p264 - 264'd1;
        vecs[4] = 264'd1 << 255;
        vecs[5] = {264{1'b1}};
        for (int i = 0; i < 6; i++) begin
            start(vecs[i]);
            wait_idle();
        end

        for (int k = 0; k < 6; k++) begin
            for (int w = 0; w < 9; w++) rv[w*32 +: 32] = $urandom();
            if (k == 0) rv[263:255] = 9'h1FF;
            start(rv);
            wait_idle();
        end

        // Random backpressure, en pulsed mid-stream, then back-to-back start.
        rand_ready = 1'b1;
        start({264{1'b1}});
        repeat (5) @(posedge clk);
        #1;
        bus.en = 1'b1;
        bus.a  = 264'h1234_5678;
        @(posedge clk); #1;
        bus.en = 1'b0;
        for (int w = 0; w < 9; w++) rv[w*32 +: 32] = $urandom();
        start(rv);
        wait_idle();
        rand_ready = 1'b0;

        // Reset while beat 10 is on the bus.
        start({264{1'b1}});
        repeat (10) @(posedge clk);
        #1;
        chk("beats_before_reset", 264'(exp_q.size()), 264'(22));
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_busy",      264'(bus.busy),      264'(0));
        chk("midrst_out_valid", 264'(bus.out_valid), 264'(0));
        chk("midrst_out_last",  264'(bus.out_last),  264'(0));
        exp_q.delete();
        exp_last_q.delete();
        rst_n = 1'b1;
        start(264'd1 << 255);
        wait_idle();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire
